// File: rtl/run_monitor_pkg.sv
// Shared types for the run controller: FSM state encoding and the watch-channel verdict.
package run_monitor_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} run_state_t;

    // Verdict index is fixed-width so the struct can live in a package; supports up to 256 channels.
    localparam int IDX_W = 8;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
        logic             pass;
    } verdict_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/run_monitor_if.sv
// Core-side bus: the core's data-memory write port plus the reset the monitor drives back into the core.
// The core presents a store for exactly the cycles MemWrite is high; there is no back-pressure.
interface run_monitor_if #(
    parameter int WIDTH = 32
);
    logic             MemWrite;
    logic [WIDTH-1:0] DataAdr;
    logic [WIDTH-1:0] WriteData;
    logic             dut_reset;

    modport master (output MemWrite, output DataAdr, output WriteData, input dut_reset);
    modport slave  (input MemWrite, input DataAdr, input WriteData, output dut_reset);
endinterface

// File: rtl/run_monitor_watch_match.sv
// Combinational priority comparator: reports the lowest-numbered channel whose address/data match a store.
module watch_match
    import run_monitor_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NUM_WATCH = 2
) (
    input  logic                            i_mem_write,
    input  logic [WIDTH-1:0]                i_adr,
    input  logic [WIDTH-1:0]                i_dat,
    input  logic [NUM_WATCH-1:0][WIDTH-1:0] i_watch_adr,
    input  logic [NUM_WATCH-1:0][WIDTH-1:0] i_watch_dat,
    input  logic [NUM_WATCH-1:0]            i_watch_pass,
    output verdict_t                        o_verdict
);

    // Walk from the highest channel down so the lowest match is the one left standing.
    always_comb begin
        o_verdict = '0;
        for (int i = NUM_WATCH - 1; i >= 0; i--) begin
            if (i_mem_write && (i_adr == i_watch_adr[i]) && (i_dat == i_watch_dat[i])) begin
                o_verdict.hit  = 1'b1;
                o_verdict.idx  = IDX_W'(i);
                o_verdict.pass = i_watch_pass[i];
            end
        end
    end

endmodule

// File: rtl/run_monitor.sv
// Run controller: holds the core in reset, lets it run, and ends the run on a watched store or a timeout.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int NUM_WATCH    = 2,
    parameter int RESET_CYCLES = 2,
    parameter int TIMEOUT      = 1024,
    parameter int CW           = 32,
    parameter bit AUTO_START   = 1'b1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [NUM_WATCH-1:0][WIDTH-1:0]     watch_adr,
    input  logic [NUM_WATCH-1:0][WIDTH-1:0]     watch_dat,
    input  logic [NUM_WATCH-1:0]                watch_pass,
    run_monitor_if.slave                        bus,
    output logic                                done,
    output logic                                pass,
    output logic                                fail,
    output logic                                timed_out,
    output logic [idx_width(NUM_WATCH)-1:0]     hit_idx,
    output logic [CW-1:0]                       cycles,
    output logic [CW-1:0]                       writes,
    output run_state_t                          dbg_state
);

    localparam int         IW        = idx_width(NUM_WATCH);
    localparam int         HW        = $clog2(RESET_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
    localparam bit         TO_EN     = (TIMEOUT != 0);
    localparam logic [CW-1:0] TO_LAST = TO_EN ? CW'(TIMEOUT - 1) : '0;
    localparam run_state_t RESET_ST  = AUTO_START ? HOLD : IDLE;

    run_state_t    r_state, w_next;
    logic [HW-1:0] r_hold_cnt;
    logic          r_dut_reset;
    logic          r_done, r_pass, r_fail, r_timed_out;
    logic [IW-1:0] r_hit_idx;
    logic [CW-1:0] r_cycles, r_writes;
    logic          w_clear, w_in_run, w_timeout;
    verdict_t      w_verdict;
    logic          w_unused_idx;

    assign w_in_run  = (r_state == RUN);
    assign w_timeout = TO_EN && w_in_run && (r_cycles == TO_LAST);

    watch_match #(
        .WIDTH     (WIDTH),
        .NUM_WATCH (NUM_WATCH)
    ) u_watch_match (
        .i_mem_write  (bus.MemWrite && w_in_run),
        .i_adr        (bus.DataAdr),
        .i_dat        (bus.WriteData),
        .i_watch_adr  (watch_adr),
        .i_watch_dat  (watch_dat),
        .i_watch_pass (watch_pass),
        .o_verdict    (w_verdict)
    );

    assign w_unused_idx = ^w_verdict.idx;

    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next  = HOLD;
                    w_clear = 1'b1;
                end
            end
            HOLD: begin
                if (r_hold_cnt == HOLD_LAST) w_next = RUN;
            end
            RUN: begin
                if (w_verdict.hit || w_timeout) w_next = DONE;
            end
            DONE: begin
                if (start) begin
                    w_next  = HOLD;
                    w_clear = 1'b1;
                end
            end
            default: w_next = RESET_ST;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= RESET_ST;
            r_hold_cnt  <= '0;
            r_dut_reset <= 1'b1;
        end else begin
            r_state     <= w_next;
            r_hold_cnt  <= (r_state == HOLD) ? r_hold_cnt + HW'(1) : '0;
            r_dut_reset <= (w_next != RUN);
        end
    end

    // A hit takes precedence over a timeout landing on the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timed_out <= 1'b0;
            r_hit_idx   <= '0;
            r_cycles    <= '0;
            r_writes    <= '0;
        end else if (w_clear) begin
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timed_out <= 1'b0;
            r_hit_idx   <= '0;
            r_cycles    <= '0;
            r_writes    <= '0;
        end else if (w_in_run) begin
            if (r_cycles != '1) r_cycles <= r_cycles + CW'(1);
            if (bus.MemWrite && (r_writes != '1)) r_writes <= r_writes + CW'(1);
            if (w_verdict.hit) begin
                r_done    <= 1'b1;
                r_hit_idx <= w_verdict.idx[IW-1:0];
                r_pass    <= w_verdict.pass;
                r_fail    <= ~w_verdict.pass;
            end else if (w_timeout) begin
                r_done      <= 1'b1;
                r_fail      <= 1'b1;
                r_timed_out <= 1'b1;
                r_hit_idx   <= '0;
            end
        end
    end

    assign bus.dut_reset = r_dut_reset;
    assign done          = r_done;
    assign pass          = r_pass;
    assign fail          = r_fail;
    assign timed_out     = r_timed_out;
    assign hit_idx       = r_hit_idx;
    assign cycles        = r_cycles;
    assign writes        = r_writes;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: expected run verdicts are queued by the stimulus and checked when done rises.
module tb_run_monitor;
    import run_monitor_pkg::*;

    localparam int WIDTH = 32;
    localparam int NW    = 2;
    localparam int RC    = 2;
    localparam int TO    = 16;
    localparam int CW    = 32;
    localparam int EW    = 4 + 2 * CW;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic [NW-1:0][WIDTH-1:0] watch_adr, watch_dat;
    logic [NW-1:0]            watch_pass;
    logic done, pass, fail, timed_out;
    logic [0:0]    hit_idx;
    logic [CW-1:0] cycles, writes;
    run_state_t    dbg_state;

    run_monitor_if #(.WIDTH(WIDTH)) bus ();

    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_q[$];

    run_monitor #(
        .WIDTH(WIDTH), .NUM_WATCH(NW), .RESET_CYCLES(RC), .TIMEOUT(TO), .CW(CW), .AUTO_START(1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .watch_adr  (watch_adr),
        .watch_dat  (watch_dat),
        .watch_pass (watch_pass),
        .bus        (bus),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .timed_out  (timed_out),
        .hit_idx    (hit_idx),
        .cycles     (cycles),
        .writes     (writes),
        .dbg_state  (dbg_state)
    );

    // clock/reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [EW-1:0] mk_exp(input logic p, input logic f, input logic t,
                                             input logic idx, input int c, input int w);
        return {p, f, t, idx, CW'(c), CW'(w)};
    endfunction

    // scoreboard monitor
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (done && !prev_done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done=1 at cycles=%0d, expected no verdict", cycles);
            end else begin
                e = exp_q.pop_front();
                check("verdict_pass",      64'(pass),      64'(e[EW-1]));
                check("verdict_fail",      64'(fail),      64'(e[EW-2]));
                check("verdict_timed_out", 64'(timed_out), 64'(e[EW-3]));
                check("verdict_hit_idx",   64'(hit_idx),   64'(e[2*CW]));
                check("verdict_cycles",    64'(cycles),    64'(e[2*CW-1:CW]));
                check("verdict_writes",    64'(writes),    64'(e[CW-1:0]));
            end
        end
        prev_done = done;
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic store(input logic en, input logic [WIDTH-1:0] adr, input logic [WIDTH-1:0] dat);
        bus.MemWrite  = en;
        bus.DataAdr   = adr;
        bus.WriteData = dat;
        step();
        bus.MemWrite  = 1'b0;
    endtask

    task automatic restart();
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_done",      64'(done),          64'd0);
        check("restart_fail",      64'(fail),          64'd0);
        check("restart_timed_out", 64'(timed_out),     64'd0);
        check("restart_cycles",    64'(cycles),        64'd0);
        check("restart_writes",    64'(writes),        64'd0);
        check("restart_dut_reset", 64'(bus.dut_reset), 64'd1);
        step();
        check("restart_hold2_dut_reset", 64'(bus.dut_reset), 64'd1);
        step();
        check("restart_run_dut_reset", 64'(bus.dut_reset), 64'd0);
        check("restart_run_state",     64'(dbg_state),     64'(RUN));
    endtask

    initial begin
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = '0;
        bus.WriteData = '0;
        watch_adr[0] = 100; watch_dat[0] = 25; watch_pass[0] = 1'b1;
        watch_adr[1] = 104; watch_dat[1] = 1;  watch_pass[1] = 1'b0;

        // reset state and auto-start hold sequence
        repeat (3) @(negedge clk);
        check("reset_dut_reset", 64'(bus.dut_reset), 64'd1);
        check("reset_done",      64'(done),          64'd0);
        check("reset_cycles",    64'(cycles),        64'd0);
        check("reset_state",     64'(dbg_state),     64'(HOLD));
        reset = 1'b1;
        step();
        check("hold1_dut_reset", 64'(bus.dut_reset), 64'd1);
        step();
        check("run_dut_reset", 64'(bus.dut_reset), 64'd0);
        check("run_cycles0",   64'(cycles),        64'd0);
        step();
        check("run_cycles1",   64'(cycles),        64'd1);

        // passing hit on channel 0 in RUN cycle 10
        idle(9);
        check("pre_hit_cycles", 64'(cycles), 64'd10);
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b0, 1'b0, 11, 1));
        store(1'b1, 100, 25);
        check("hit_dut_reset", 64'(bus.dut_reset), 64'd1);
        store(1'b1, 104, 1);
        idle(2);
        check("done_hold_cycles", 64'(cycles), 64'd11);
        check("done_hold_writes", 64'(writes), 64'd1);
        check("done_hold_pass",   64'(pass),   64'd1);

        // failing hit on channel 1 after a non-matching store and a strobe-less match
        restart();
        idle(1);
        store(1'b0, 104, 1);
        store(1'b1, 100, 24);
        idle(1);
        exp_q.push_back(mk_exp(1'b0, 1'b1, 1'b0, 1'b1, 5, 2));
        store(1'b1, 104, 1);

        // both channels match: lowest index wins
        watch_adr[1] = 100; watch_dat[1] = 25;
        restart();
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b0, 1'b0, 1, 1));
        store(1'b1, 100, 25);
        watch_adr[1] = 104; watch_dat[1] = 1;

        // timeout with no stores
        restart();
        exp_q.push_back(mk_exp(1'b0, 1'b1, 1'b1, 1'b0, 16, 0));
        idle(16);
        check("timeout_dut_reset", 64'(bus.dut_reset), 64'd1);
        idle(2);
        check("timeout_cycles_hold", 64'(cycles), 64'd16);

        // hit on the last cycle beats the timeout
        restart();
        idle(15);
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b0, 1'b0, 16, 1));
        store(1'b1, 100, 25);
        check("late_hit_timed_out", 64'(timed_out), 64'd0);

        // asynchronous abort mid-run, then auto-start again
        restart();
        idle(3);
        #2;
        reset = 1'b0;
        #1;
        check("abort_dut_reset", 64'(bus.dut_reset), 64'd1);
        check("abort_cycles",    64'(cycles),        64'd0);
        check("abort_state",     64'(dbg_state),     64'(HOLD));
        @(negedge clk);
        reset = 1'b1;
        step();
        check("abort_hold1_dut_reset", 64'(bus.dut_reset), 64'd1);
        step();
        check("abort_run_dut_reset", 64'(bus.dut_reset), 64'd0);
        check("abort_run_cycles",    64'(cycles),        64'd0);

        idle(2);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
